// File: rtl/text_cursor_ctrl.sv
// text_cursor_ctrl: UART byte stream to 4x32 text RAM write sequencer with cursor,
// backspace, newline and multi-cycle row/screen clear sweeps.  Rev 1.0
`default_nettype none

module text_cursor_ctrl #(
  parameter int unsigned COL_START        = 24,
  parameter logic [7:0]  NEWLINE_CODE     = 8'h0D,
  parameter bit          CLEAR_ON_NEWLINE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  output logic       o_ram_we,
  output logic [1:0] o_ram_row,
  output logic [4:0] o_ram_col,
  output logic [7:0] o_ram_wdata,
  output logic [1:0] o_cur_row,
  output logic [4:0] o_cur_col,
  output logic       o_busy,
  output logic       o_overflow
);

  localparam logic [4:0] c_col_off = 5'(COL_START % 32);
  localparam logic [7:0] c_space   = 8'h20;
  localparam logic [7:0] c_bs      = 8'h08;
  localparam logic [7:0] c_ff      = 8'h0C;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_LINE_CLR = 2'd1,
    S_SCR_CLR  = 2'd2
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [6:0] r_cnt, w_cnt_nxt;
  logic [1:0] r_clr_row, w_clr_row_nxt;
  logic [1:0] r_cur_row, w_cur_row_nxt;
  logic [4:0] r_cur_col, w_cur_col_nxt;
  logic       r_we, w_we_nxt;
  logic [1:0] r_row, w_row_nxt;
  logic [4:0] r_col, w_col_nxt;
  logic [7:0] r_wdata, w_wdata_nxt;
  logic       r_overflow, w_overflow_nxt;
  logic [1:0] w_row_inc;
  logic [4:0] w_col_dec;

  assign w_row_inc = r_cur_row + 2'd1;
  assign w_col_dec = r_cur_col - 5'd1;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_clr_row_nxt  = r_clr_row;
    w_cur_row_nxt  = r_cur_row;
    w_cur_col_nxt  = r_cur_col;
    w_we_nxt       = 1'b0;
    w_row_nxt      = r_row;
    w_col_nxt      = r_col;
    w_wdata_nxt    = r_wdata;
    w_overflow_nxt = r_overflow;

    // Any byte offered while a sweep runs is lost; remember that it happened.
    if (i_rx_valid && (r_state != S_IDLE)) begin
      w_overflow_nxt = 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        if (i_rx_valid) begin
          if (i_rx_data == NEWLINE_CODE) begin
            w_cur_col_nxt = 5'd0;
            w_cur_row_nxt = w_row_inc;
            if (CLEAR_ON_NEWLINE) begin
              w_state_nxt   = S_LINE_CLR;
              w_clr_row_nxt = w_row_inc;
              w_cnt_nxt     = 7'd0;
            end
          end else if (i_rx_data == c_bs) begin
            if (r_cur_col != 5'd0) begin
              w_cur_col_nxt = w_col_dec;
              w_we_nxt      = 1'b1;
              w_row_nxt     = r_cur_row;
              w_col_nxt     = w_col_dec + c_col_off;
              w_wdata_nxt   = c_space;
            end
          end else if (i_rx_data == c_ff) begin
            w_cur_col_nxt = 5'd0;
            w_cur_row_nxt = 2'd0;
            w_state_nxt   = S_SCR_CLR;
            w_cnt_nxt     = 7'd0;
          end else if ((i_rx_data >= 8'h20) && (i_rx_data <= 8'h7E)) begin
            w_we_nxt    = 1'b1;
            w_row_nxt   = r_cur_row;
            w_col_nxt   = r_cur_col + c_col_off;
            w_wdata_nxt = i_rx_data;
            if (r_cur_col == 5'd31) begin
              w_cur_col_nxt = 5'd0;
              w_cur_row_nxt = w_row_inc;
              if (CLEAR_ON_NEWLINE) begin
                w_state_nxt   = S_LINE_CLR;
                w_clr_row_nxt = w_row_inc;
                w_cnt_nxt     = 7'd0;
              end
            end else begin
              w_cur_col_nxt = r_cur_col + 5'd1;
            end
          end
        end
      end

      S_LINE_CLR: begin
        w_we_nxt    = 1'b1;
        w_row_nxt   = r_clr_row;
        w_col_nxt   = r_cnt[4:0];
        w_wdata_nxt = c_space;
        w_cnt_nxt   = r_cnt + 7'd1;
        if (r_cnt[4:0] == 5'd31) begin
          w_state_nxt = S_IDLE;
        end
      end

      S_SCR_CLR: begin
        w_we_nxt    = 1'b1;
        w_row_nxt   = r_cnt[6:5];
        w_col_nxt   = r_cnt[4:0];
        w_wdata_nxt = c_space;
        w_cnt_nxt   = r_cnt + 7'd1;
        if (r_cnt == 7'd127) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 7'd0;
      r_clr_row  <= 2'd0;
      r_cur_row  <= 2'd0;
      r_cur_col  <= 5'd0;
      r_we       <= 1'b0;
      r_row      <= 2'd0;
      r_col      <= 5'd0;
      r_wdata    <= 8'd0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_clr_row  <= w_clr_row_nxt;
      r_cur_row  <= w_cur_row_nxt;
      r_cur_col  <= w_cur_col_nxt;
      r_we       <= w_we_nxt;
      r_row      <= w_row_nxt;
      r_col      <= w_col_nxt;
      r_wdata    <= w_wdata_nxt;
      r_overflow <= w_overflow_nxt;
    end
  end

  assign o_ram_we    = r_we;
  assign o_ram_row   = r_row;
  assign o_ram_col   = r_col;
  assign o_ram_wdata = r_wdata;
  assign o_cur_row   = r_cur_row;
  assign o_cur_col   = r_cur_col;
  assign o_busy      = (r_state != S_IDLE);
  assign o_overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_text_cursor_ctrl.sv
// tb_text_cursor_ctrl: directed table-driven checks plus sweep, wrap, overflow and
// mid-sweep reset sequences for text_cursor_ctrl.  Rev 1.0
`default_nettype none

module tb_text_cursor_ctrl;

  logic       clk;
  logic       reset;
  logic [7:0] i_rx_data;
  logic       i_rx_valid;
  logic       o_ram_we;
  logic [1:0] o_ram_row;
  logic [4:0] o_ram_col;
  logic [7:0] o_ram_wdata;
  logic [1:0] o_cur_row;
  logic [4:0] o_cur_col;
  logic       o_busy;
  logic       o_overflow;

  int checks   = 0;
  int failures = 0;

  text_cursor_ctrl #(
    .COL_START(24),
    .NEWLINE_CODE(8'h0D),
    .CLEAR_ON_NEWLINE(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_rx_data(i_rx_data),
    .i_rx_valid(i_rx_valid),
    .o_ram_we(o_ram_we),
    .o_ram_row(o_ram_row),
    .o_ram_col(o_ram_col),
    .o_ram_wdata(o_ram_wdata),
    .o_cur_row(o_cur_row),
    .o_cur_col(o_cur_col),
    .o_busy(o_busy),
    .o_overflow(o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       we;
    logic [4:0] col;
    logic [7:0] wdata;
    logic [1:0] cur_row;
    logic [4:0] cur_col;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic [7:0] d, input logic we, input logic [4:0] col,
                              input logic [7:0] wd, input logic [1:0] cr, input logic [4:0] cc);
    vec_t v;
    v.data = d; v.we = we; v.col = col; v.wdata = wd; v.cur_row = cr; v.cur_col = cc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Present one byte for exactly one rising edge; returns 1 ns after that edge.
  task automatic send(input logic [7:0] d);
    @(negedge clk);
    i_rx_data  = d;
    i_rx_valid = 1'b1;
    @(posedge clk);
    #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (o_busy && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("sweep_timeout_busy", {31'd0, o_busy}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int writes;
    reset      = 1'b0;
    i_rx_data  = 8'h00;
    i_rx_valid = 1'b0;

    vecs[0]  = mk(8'h41, 1'b1, 5'd24, 8'h41, 2'd0, 5'd1);
    vecs[1]  = mk(8'h42, 1'b1, 5'd25, 8'h42, 2'd0, 5'd2);
    vecs[2]  = mk(8'h07, 1'b0, 5'd0,  8'h00, 2'd0, 5'd2);
    vecs[3]  = mk(8'h9A, 1'b0, 5'd0,  8'h00, 2'd0, 5'd2);
    vecs[4]  = mk(8'h7F, 1'b0, 5'd0,  8'h00, 2'd0, 5'd2);
    vecs[5]  = mk(8'h08, 1'b1, 5'd25, 8'h20, 2'd0, 5'd1);
    vecs[6]  = mk(8'h08, 1'b1, 5'd24, 8'h20, 2'd0, 5'd0);
    vecs[7]  = mk(8'h08, 1'b0, 5'd0,  8'h00, 2'd0, 5'd0);
    vecs[8]  = mk(8'h7E, 1'b1, 5'd24, 8'h7E, 2'd0, 5'd1);
    vecs[9]  = mk(8'h20, 1'b1, 5'd25, 8'h20, 2'd0, 5'd2);
    vecs[10] = mk(8'h61, 1'b1, 5'd26, 8'h61, 2'd0, 5'd3);
    vecs[11] = mk(8'h62, 1'b1, 5'd27, 8'h62, 2'd0, 5'd4);
    vecs[12] = mk(8'h63, 1'b1, 5'd28, 8'h63, 2'd0, 5'd5);
    vecs[13] = mk(8'h08, 1'b1, 5'd28, 8'h20, 2'd0, 5'd4);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_we",       {31'd0, o_ram_we},    32'd0);
    chk("rst_row",      {30'd0, o_ram_row},   32'd0);
    chk("rst_col",      {27'd0, o_ram_col},   32'd0);
    chk("rst_wdata",    {24'd0, o_ram_wdata}, 32'd0);
    chk("rst_cur_row",  {30'd0, o_cur_row},   32'd0);
    chk("rst_cur_col",  {27'd0, o_cur_col},   32'd0);
    chk("rst_busy",     {31'd0, o_busy},      32'd0);
    chk("rst_overflow", {31'd0, o_overflow},  32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      send(vecs[i].data);
      chk($sformatf("vec%0d_we", i), {31'd0, o_ram_we}, {31'd0, vecs[i].we});
      if (vecs[i].we) begin
        chk($sformatf("vec%0d_row", i),   {30'd0, o_ram_row},   32'd0);
        chk($sformatf("vec%0d_col", i),   {27'd0, o_ram_col},   {27'd0, vecs[i].col});
        chk($sformatf("vec%0d_wdata", i), {24'd0, o_ram_wdata}, {24'd0, vecs[i].wdata});
      end
      chk($sformatf("vec%0d_cur_row", i), {30'd0, o_cur_row}, {30'd0, vecs[i].cur_row});
      chk($sformatf("vec%0d_cur_col", i), {27'd0, o_cur_col}, {27'd0, vecs[i].cur_col});
      chk($sformatf("vec%0d_busy", i),    {31'd0, o_busy},    32'd0);
    end

    // Form feed: 128 space writes in row-major order, cursor homed at entry.
    send(8'h0C);
    chk("ff_accept_we", {31'd0, o_ram_we}, 32'd0);
    chk("ff_busy",      {31'd0, o_busy},   32'd1);
    chk("ff_cur",       {25'd0, o_cur_row, o_cur_col}, 32'd0);
    for (int i = 0; i < 128; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("ff%0d_we", i),    {31'd0, o_ram_we},    32'd1);
      chk($sformatf("ff%0d_cell", i),  {25'd0, o_ram_row, o_ram_col}, 32'(i));
      chk($sformatf("ff%0d_wdata", i), {24'd0, o_ram_wdata}, 32'h20);
      chk($sformatf("ff%0d_busy", i),  {31'd0, o_busy},      (i < 127) ? 32'd1 : 32'd0);
    end
    @(posedge clk);
    #1;
    chk("ff_done_we", {31'd0, o_ram_we}, 32'd0);

    // 32 characters from (0,0): wrap into row 1, then row 1 is cleared.
    for (int i = 0; i < 32; i++) begin
      send(8'h41 + 8'(i % 26));
      chk($sformatf("wrap%0d_we", i),    {31'd0, o_ram_we},    32'd1);
      chk($sformatf("wrap%0d_row", i),   {30'd0, o_ram_row},   32'd0);
      chk($sformatf("wrap%0d_col", i),   {27'd0, o_ram_col},   32'((24 + i) % 32));
      chk($sformatf("wrap%0d_wdata", i), {24'd0, o_ram_wdata}, 32'h41 + 32'(i % 26));
      chk($sformatf("wrap%0d_busy", i),  {31'd0, o_busy},      (i == 31) ? 32'd1 : 32'd0);
    end
    chk("wrap_cur", {25'd0, o_cur_row, o_cur_col}, {25'd0, 2'd1, 5'd0});
    for (int k = 0; k < 32; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("lclr%0d_we", k),    {31'd0, o_ram_we},    32'd1);
      chk($sformatf("lclr%0d_cell", k),  {25'd0, o_ram_row, o_ram_col}, {25'd0, 2'd1, 5'(k)});
      chk($sformatf("lclr%0d_wdata", k), {24'd0, o_ram_wdata}, 32'h20);
      chk($sformatf("lclr%0d_busy", k),  {31'd0, o_busy},      (k < 31) ? 32'd1 : 32'd0);
    end
    @(posedge clk);
    #1;
    chk("lclr_done_we", {31'd0, o_ram_we}, 32'd0);

    // Newlines: row 1 -> 2 -> 3 -> 0 (wrap), overflow on a byte during the last sweep.
    send(8'h0D);
    chk("nl1_cur", {25'd0, o_cur_row, o_cur_col}, {25'd0, 2'd2, 5'd0});
    chk("nl1_we",  {31'd0, o_ram_we}, 32'd0);
    wait_idle();
    send(8'h0D);
    chk("nl2_cur", {25'd0, o_cur_row, o_cur_col}, {25'd0, 2'd3, 5'd0});
    wait_idle();
    send(8'h0D);
    chk("nl3_cur",  {25'd0, o_cur_row, o_cur_col}, 32'd0);
    chk("nl3_busy", {31'd0, o_busy}, 32'd1);
    chk("nl3_ovf0", {31'd0, o_overflow}, 32'd0);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      i_rx_data  = 8'h5A;
      i_rx_valid = (k == 10);
      @(posedge clk);
      #1;
      chk($sformatf("nl3_%0d_cell", k),  {25'd0, o_ram_we, o_ram_row, o_ram_col}, {25'd0, 1'b1, 2'd0, 5'(k)});
      chk($sformatf("nl3_%0d_wdata", k), {24'd0, o_ram_wdata}, 32'h20);
    end
    i_rx_valid = 1'b0;
    chk("nl3_overflow", {31'd0, o_overflow}, 32'd1);
    chk("nl3_busy_end", {31'd0, o_busy}, 32'd0);
    @(posedge clk);
    #1;
    chk("nl3_drop_we",  {31'd0, o_ram_we}, 32'd0);
    chk("nl3_drop_cur", {25'd0, o_cur_row, o_cur_col}, 32'd0);

    // Reset in the middle of a screen clear.
    send(8'h41);
    send(8'h0C);
    repeat (20) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("mrst_we",       {31'd0, o_ram_we},    32'd0);
    chk("mrst_row_col",  {25'd0, o_ram_row, o_ram_col}, 32'd0);
    chk("mrst_wdata",    {24'd0, o_ram_wdata}, 32'd0);
    chk("mrst_cur",      {25'd0, o_cur_row, o_cur_col}, 32'd0);
    chk("mrst_busy",     {31'd0, o_busy},      32'd0);
    chk("mrst_overflow", {31'd0, o_overflow},  32'd0);
    @(negedge clk);
    reset = 1'b1;
    writes = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      if (o_ram_we) writes++;
    end
    chk("mrst_no_writes", 32'(writes), 32'd0);
    chk("mrst_busy_after", {31'd0, o_busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
